// File: rtl/spi_ctrl_master.sv
// Host-side SPI controller for the register-slave protocol: one request becomes one
// nss-framed transaction (cmd byte {op,addr}, then req_len+1 data words, MSB first).
module spi_ctrl_master #(
    parameter int REG_W    = 8,
    parameter int LEN_W    = 4,
    parameter int HALF_DIV = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic [1:0]       req_op,
    input  logic [5:0]       req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic [REG_W-1:0] wr_data,
    input  logic             wr_data_vld,
    output logic             wr_data_rdy,
    output logic [REG_W-1:0] rd_data,
    output logic             rd_data_vld,
    output logic [7:0]       status,
    output logic             status_vld,
    output logic             done,
    output logic             sclk,
    output logic             mosi,
    output logic             nss,
    input  logic             miso,
    output logic [2:0]       dbg_state
);
    localparam int DIV_W = $clog2(2 * HALF_DIV) + 1;
    localparam int BIT_W = $clog2(REG_W);
    localparam logic [DIV_W-1:0] PHASE_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_LAST   = DIV_W'(2 * HALF_DIV - 1);
    localparam logic [BIT_W-1:0] CMD_LAST   = BIT_W'(7);
    localparam logic [BIT_W-1:0] WORD_LAST  = BIT_W'(REG_W - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_HI, S_LO, S_STALL, S_HOLD, S_GAP, S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [BIT_W-1:0] r_bit;
    logic [LEN_W-1:0] r_word, r_len;
    logic [1:0]       r_op;
    logic             r_in_cmd;
    logic [REG_W-1:0] r_tx, r_rx, r_rd_data;
    logic [7:0]       r_status;
    logic             r_rd_vld, r_status_vld, r_sclk, r_nss;
    logic             w_accept, w_shift, w_next_word, w_load;
    logic             w_phase_end, w_last_bit, w_last_word, w_is_wr, w_is_fc;
    logic             w_enter_hi, w_enter_hold;
    logic [REG_W-1:0] w_rx_word;

    assign w_phase_end  = (r_div == PHASE_LAST);
    assign w_last_bit   = r_in_cmd ? (r_bit == CMD_LAST) : (r_bit == WORD_LAST);
    assign w_last_word  = (r_word == r_len);
    assign w_is_wr      = (r_op == 2'b10);
    assign w_is_fc      = (r_op == 2'b11);
    assign w_enter_hi   = (w_state_nxt == S_HI) && (r_state != S_HI);
    assign w_enter_hold = (w_state_nxt == S_HOLD) && (r_state != S_HOLD);
    assign w_rx_word    = {r_rx[REG_W-2:0], miso};

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_shift     = 1'b0;
        w_next_word = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: if (req_vld) begin
                w_accept    = 1'b1;
                w_state_nxt = S_SETUP;
            end
            S_SETUP, S_LO: if (w_phase_end) w_state_nxt = S_HI;
            S_HI: if (w_phase_end) begin
                if (!w_last_bit) begin
                    w_shift     = 1'b1;
                    w_state_nxt = S_LO;
                end else if ((r_in_cmd && w_is_fc) || (!r_in_cmd && w_last_word)) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    // Falling edge that ends a byte/word: the next word must be ready now.
                    w_next_word = 1'b1;
                    if (!w_is_wr) begin
                        w_state_nxt = S_LO;
                    end else if (wr_data_vld) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_LO;
                    end else begin
                        w_state_nxt = S_STALL;
                    end
                end
            end
            S_STALL: if (wr_data_vld) begin
                w_load      = 1'b1;
                w_state_nxt = S_LO;
            end
            S_HOLD:  if (w_phase_end) w_state_nxt = S_GAP;
            S_GAP:   if (r_div == GAP_LAST) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_bit        <= '0;
            r_word       <= '0;
            r_len        <= '0;
            r_op         <= '0;
            r_in_cmd     <= 1'b0;
            r_tx         <= '0;
            r_rx         <= '0;
            r_rd_data    <= '0;
            r_status     <= '0;
            r_rd_vld     <= 1'b0;
            r_status_vld <= 1'b0;
            r_sclk       <= 1'b0;
            r_nss        <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_div        <= (w_state_nxt != r_state) ? '0 : r_div + 1'b1;
            r_sclk       <= (w_state_nxt == S_HI);
            r_nss        <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_GAP) ||
                            (w_state_nxt == S_DONE);
            r_rd_vld     <= 1'b0;
            r_status_vld <= 1'b0;
            if (w_accept) begin
                r_op                <= req_op;
                r_len               <= req_len;
                r_in_cmd            <= 1'b1;
                r_bit               <= '0;
                r_word              <= '0;
                r_tx                <= '0;
                r_tx[REG_W-1 -: 8]  <= {req_op, req_addr};
            end
            if (w_shift) begin
                r_tx  <= r_tx << 1;
                r_bit <= r_bit + 1'b1;
            end
            if (w_next_word) begin
                r_in_cmd <= 1'b0;
                r_bit    <= '0;
                r_tx     <= '0;
                if (!r_in_cmd) r_word <= r_word + 1'b1;
            end
            if (w_load) r_tx <= wr_data;
            if (w_enter_hold) r_tx <= '0;
            if (w_enter_hi) begin
                r_rx <= w_rx_word;
                if (r_in_cmd && r_bit == CMD_LAST) begin
                    r_status     <= w_rx_word[7:0];
                    r_status_vld <= 1'b1;
                end
                if (!r_in_cmd && r_bit == WORD_LAST && !w_is_wr) begin
                    r_rd_data <= w_rx_word;
                    r_rd_vld  <= 1'b1;
                end
            end
        end
    end

    assign req_rdy     = (r_state == S_IDLE);
    assign done        = (r_state == S_DONE);
    assign wr_data_rdy = w_load;
    assign rd_data     = r_rd_data;
    assign rd_data_vld = r_rd_vld;
    assign status      = r_status;
    assign status_vld  = r_status_vld;
    assign sclk        = r_sclk;
    assign nss         = r_nss;
    assign mosi        = r_tx[REG_W-1];
    assign dbg_state   = r_state;
endmodule

// File: tb/tb_spi_ctrl_master.sv
// Bench for spi_ctrl_master: behavioural SPI register slave, reference register map,
// expected-value queues popped by a monitor whenever the DUT flags an output.
module tb_spi_ctrl_master;
    localparam int REG_W    = 8;
    localparam int LEN_W    = 4;
    localparam int HALF_DIV = 4;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             req_vld = 1'b0;
    logic             req_rdy;
    logic [1:0]       req_op = '0;
    logic [5:0]       req_addr = '0;
    logic [LEN_W-1:0] req_len = '0;
    logic [REG_W-1:0] wr_data = '0;
    logic             wr_data_vld = 1'b0;
    logic             wr_data_rdy;
    logic [REG_W-1:0] rd_data;
    logic             rd_data_vld;
    logic [7:0]       status;
    logic             status_vld;
    logic             done;
    logic             sclk, mosi, nss;
    logic             miso = 1'b0;
    logic [2:0]       dbg_state;

    always #5 clk = ~clk;

    spi_ctrl_master #(.REG_W(REG_W), .LEN_W(LEN_W), .HALF_DIV(HALF_DIV)) dut (
        .clk(clk), .nrst(nrst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op), .req_addr(req_addr),
        .req_len(req_len), .wr_data(wr_data), .wr_data_vld(wr_data_vld),
        .wr_data_rdy(wr_data_rdy), .rd_data(rd_data), .rd_data_vld(rd_data_vld),
        .status(status), .status_vld(status_vld), .done(done),
        .sclk(sclk), .mosi(mosi), .nss(nss), .miso(miso), .dbg_state(dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [REG_W-1:0] exp_rd_q[$];
    logic [7:0]       exp_status_q[$];
    logic [7:0]       feed_q[$];
    int               feed_dly_q[$];
    logic [7:0]       dir_data_q[$];
    logic [7:0]       ref_regs[64];
    int  feed_consumed = 0;
    int  feed_wait = 0;
    bit  feed_armed = 1'b0;
    int  done_cnt = 0;
    int  low_run = 0;
    int  max_low_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural register slave: cmd byte, then auto-incrementing register words.
    logic [7:0] slv_regs[64];
    logic [7:0] slv_status = 8'h00;
    logic [5:0] slv_fastcmd = '0;
    logic [7:0] slv_in = '0, slv_out = '0, slv_cmd = '0;
    logic [5:0] slv_ptr = '0;
    int slv_nbits = 0;
    int slv_rises = 0;
    int rd_mosi_bad = 0;

    always @(negedge nss) begin
        slv_nbits = 0;
        slv_rises = 0;
        slv_out   = slv_status;
        miso      = slv_status[7];
    end

    always @(posedge sclk) if (nss === 1'b0) begin
        slv_rises++;
        if (slv_nbits >= 8 && slv_cmd[7] == 1'b0 && mosi !== 1'b0) rd_mosi_bad++;
        slv_in = {slv_in[6:0], mosi};
        slv_nbits++;
        if (slv_nbits % 8 == 0) begin
            if (slv_nbits == 8) begin
                slv_cmd = slv_in;
                slv_ptr = slv_in[5:0];
                if (slv_in[7:6] == 2'b11) slv_fastcmd = slv_in[5:0];
            end else begin
                if (slv_cmd[7:6] == 2'b10) slv_regs[slv_ptr] = slv_in;
                slv_ptr++;
            end
            slv_out = (slv_cmd[7] == 1'b0) ? slv_regs[slv_ptr] : 8'h00;
        end else begin
            slv_out = slv_out << 1;
        end
    end

    always @(negedge sclk) if (nss === 1'b0) miso = slv_out[7];

    // Monitor: pops expectations whenever the DUT flags a result.
    always @(negedge clk) begin
        if (nrst) begin
            if (rd_data_vld) begin
                check("rd_expected", 32'(exp_rd_q.size() != 0), 32'd1);
                if (exp_rd_q.size() != 0) check("rd_data", 32'(rd_data), 32'(exp_rd_q.pop_front()));
            end
            if (status_vld) begin
                check("status_expected", 32'(exp_status_q.size() != 0), 32'd1);
                if (exp_status_q.size() != 0) check("status", 32'(status), 32'(exp_status_q.pop_front()));
            end
            if (done) done_cnt++;
            if (!nss && !sclk) begin
                low_run++;
                if (low_run > max_low_run) max_low_run = low_run;
            end else begin
                low_run = 0;
            end
        end
    end

    // Write-data source: per-word delay, handshake sampled before the consuming edge.
    initial begin
        forever begin
            @(negedge clk);
            wr_data_vld = 1'b0;
            if (feed_q.size() > 0 && nrst) begin
                if (!feed_armed) begin
                    feed_wait  = feed_dly_q.pop_front();
                    feed_armed = 1'b1;
                end
                if (feed_wait > 0) begin
                    feed_wait--;
                end else begin
                    wr_data     = feed_q[0];
                    wr_data_vld = 1'b1;
                    #1;
                    if (wr_data_rdy) begin
                        void'(feed_q.pop_front());
                        feed_armed = 1'b0;
                        feed_consumed++;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [5:0] addr, input logic [LEN_W-1:0] len);
        int t = 0;
        @(negedge clk);
        while (!req_rdy && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("req_rdy_idle", 32'(req_rdy), 32'd1);
        req_vld  = 1'b1;
        req_op   = op;
        req_addr = addr;
        req_len  = len;
        @(negedge clk);
        req_vld  = 1'b0;
        req_op   = 2'($urandom);
        req_addr = 6'($urandom);
        req_len  = LEN_W'($urandom);
        check("req_rdy_busy", 32'(req_rdy), 32'd0);
    endtask

    task automatic wait_done;
        int t = 0;
        while (done !== 1'b1 && t < 6000) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("rdy_during_done", 32'(req_rdy), 32'd0);
        @(negedge clk);
        check("rdy_after_done", 32'(req_rdy), 32'd1);
        check("nss_after_done", 32'(nss), 32'd1);
    endtask

    task automatic run_txn(input logic [1:0] op, input logic [5:0] addr, input logic [LEN_W-1:0] len,
                           input logic [7:0] st, input int stall_word, input int stall_clks,
                           input bit junk);
        int nw;
        int done0;
        int fed0;
        logic [7:0] d;
        logic [5:0] idx;
        nw = (op == 2'b11) ? 0 : int'(len) + 1;
        slv_status = st;
        exp_status_q.push_back(st);
        for (int i = 0; i < nw; i++) begin
            idx = addr + 6'(i);
            if (op == 2'b10) begin
                d = (dir_data_q.size() != 0) ? dir_data_q.pop_front() : 8'($urandom);
                feed_q.push_back(d);
                feed_dly_q.push_back((i == stall_word) ? stall_clks : int'($urandom_range(0, 3)));
                ref_regs[idx] = d;
            end else begin
                exp_rd_q.push_back(ref_regs[idx]);
            end
        end
        done0 = done_cnt;
        fed0  = feed_consumed;
        max_low_run = 0;
        issue(op, addr, len);
        if (junk) begin
            for (int i = 0; i < 20; i++) begin
                req_vld  = 1'b1;
                req_op   = 2'($urandom);
                req_addr = 6'($urandom);
                @(negedge clk);
            end
            req_vld = 1'b0;
        end
        wait_done();
        repeat (3) @(negedge clk);
        check("done_count", 32'(done_cnt - done0), 32'd1);
        check("sclk_rises", 32'(slv_rises), 32'(8 + 8 * nw));
        check("wr_words", 32'(feed_consumed - fed0), 32'((op == 2'b10) ? nw : 0));
        if (op == 2'b11) check("fastcmd_code", 32'(slv_fastcmd), 32'(addr));
    endtask

    initial begin
        logic [7:0] v;
        int t;
        int done0;
        logic [1:0] rop;
        logic [LEN_W-1:0] rlen;
        int sw;
        for (int i = 0; i < 64; i++) begin
            v = 8'($urandom);
            slv_regs[i] = v;
            ref_regs[i] = v;
        end

        repeat (3) @(negedge clk);
        check("rst_nss", 32'(nss), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_req_rdy", 32'(req_rdy), 32'd1);
        check("rst_pulses", 32'({wr_data_rdy, rd_data_vld, status_vld, done}), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        dir_data_q.push_back(8'h11);
        dir_data_q.push_back(8'h22);
        run_txn(2'b10, 6'd3, 4'd1, 8'hA5, -1, 0, 1'b0);
        check("wr_reg3", 32'(slv_regs[3]), 32'h11);
        check("wr_reg4", 32'(slv_regs[4]), 32'h22);

        slv_regs[5] = 8'h5A; ref_regs[5] = 8'h5A;
        slv_regs[6] = 8'hC3; ref_regs[6] = 8'hC3;
        slv_regs[7] = 8'h0F; ref_regs[7] = 8'h0F;
        run_txn(2'b00, 6'd5, 4'd2, 8'h3C, -1, 0, 1'b0);

        run_txn(2'b11, 6'h2A, 4'd9, 8'h81, -1, 0, 1'b0);

        run_txn(2'b10, 6'd10, 4'd3, 8'h7E, 2, 120, 1'b0);
        check("stall_low_run", 32'(max_low_run >= 50), 32'd1);

        done0 = done_cnt;
        issue(2'b00, 6'd20, 4'd3);
        t = 0;
        while (slv_rises < 5 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("abort_reach5", 32'(slv_rises >= 5), 32'd1);
        #2 nrst = 1'b0;
        #1;
        check("abort_nss", 32'(nss), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_req_rdy", 32'(req_rdy), 32'd1);
        repeat (4) @(negedge clk);
        nrst = 1'b1;
        repeat (60) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - done0), 32'd0);
        run_txn(2'b00, 6'd20, 4'd3, 8'h5F, -1, 0, 1'b0);

        run_txn(2'b10, 6'd60, 4'hF, 8'hE1, -1, 0, 1'b1);
        run_txn(2'b01, 6'd60, 4'hF, 8'h1E, -1, 0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            rop  = 2'($urandom_range(0, 3));
            rlen = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            sw   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(rlen))) : -1;
            run_txn(rop, 6'($urandom), rlen, 8'($urandom), sw, 100, 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 64; i++) check($sformatf("reg_%0d", i), 32'(slv_regs[i]), 32'(ref_regs[i]));
        check("rd_mosi_zero", 32'(rd_mosi_bad), 32'd0);
        check("rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
        check("status_q_empty", 32'(exp_status_q.size()), 32'd0);
        check("feed_q_empty", 32'(feed_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
